j17_control_unit: RTL and testbench

//  Multi-cycle fetch/decode/sequence controller that drives the J17 DATAPATH control bus.

---
 rtl/j17_pkg.sv | 58 +++++
 rtl/j17_decoder.sv | 58 +++++
 rtl/j17_control_unit.sv | 169 ++++++++++++++++
 tb/tb_j17_control_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/j17_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | j17_pkg
// | Shared opcodes, FSM state encoding and control-bundle type for the J17 controller.
// | Rev 1.0
// +-----------------------------------------------------------------------------
package j17_pkg;

  localparam logic [5:0] OP_NOP     = 6'h00;
  localparam logic [5:0] OP_ALU_LO  = 6'h01;
  localparam logic [5:0] OP_ALU_HI  = 6'h0B;
  localparam logic [5:0] OP_IMM_LO  = 6'h11;
  localparam logic [5:0] OP_IMM_HI  = 6'h1B;
  localparam logic [5:0] OP_LOAD    = 6'h20;
  localparam logic [5:0] OP_STORE   = 6'h21;
  localparam logic [5:0] OP_BR_BASE = 6'h28;
  localparam logic [5:0] OP_HALT    = 6'h3F;

  localparam logic [4:0] C_IMM_OFS  = 5'h10;

  localparam logic [1:0] RAMEN_IDLE  = 2'b00;
  localparam logic [1:0] RAMEN_LOAD  = 2'b01;
  localparam logic [1:0] RAMEN_STORE = 2'b10;

  localparam logic [1:0] WC_ALU  = 2'd0;
  localparam logic [1:0] WC_NUM2 = 2'd1;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef struct packed {
    logic [4:0]  alucode;
    logic [4:0]  op1;
    logic [19:0] op2;
    logic        imm;
    logic [2:0]  pcctl;
    logic [1:0]  wc;
    logic [1:0]  ramen;
    logic        regwr;
    logic        is_mem;
    logic        is_halt;
    logic        legal;
  } ctrl_t;

  function automatic logic op_in(input logic [5:0] op, input logic [5:0] lo,
                                 input logic [5:0] hi);
    return (op >= lo) && (op <= hi);
  endfunction

endpackage : j17_pkg
`default_nettype wire

// File: rtl/j17_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | j17_decoder
// | Combinational instruction decode into the DATAPATH control bundle plus legal flag.
// | Rev 1.0
// +-----------------------------------------------------------------------------
module j17_decoder
  import j17_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl
);

  logic [5:0] w_op;
  logic       w_unused_bit20;

  assign w_op           = i_instr[31:26];
  assign w_unused_bit20 = i_instr[20];

  always_comb begin
    o_ctrl         = '0;
    o_ctrl.op1     = i_instr[25:21];
    o_ctrl.op2     = i_instr[19:0];
    o_ctrl.wc      = WC_ALU;
    o_ctrl.ramen   = RAMEN_IDLE;
    o_ctrl.legal   = 1'b1;

    if (w_op == OP_NOP) begin
      o_ctrl.pcctl = 3'd0;
    end else if (op_in(w_op, OP_ALU_LO, OP_ALU_HI)) begin
      o_ctrl.alucode = w_op[4:0];
      o_ctrl.regwr   = 1'b1;
    end else if (op_in(w_op, OP_IMM_LO, OP_IMM_HI)) begin
      // Immediate forms reuse the reg-reg ALU codes, offset by 0x10.
      o_ctrl.alucode = w_op[4:0] - C_IMM_OFS;
      o_ctrl.imm     = 1'b1;
      o_ctrl.regwr   = 1'b1;
    end else if (w_op == OP_LOAD) begin
      o_ctrl.imm     = 1'b1;
      o_ctrl.ramen   = RAMEN_LOAD;
      o_ctrl.wc      = WC_NUM2;
      o_ctrl.regwr   = 1'b1;
      o_ctrl.is_mem  = 1'b1;
    end else if (w_op == OP_STORE) begin
      o_ctrl.imm     = 1'b1;
      o_ctrl.ramen   = RAMEN_STORE;
      o_ctrl.is_mem  = 1'b1;
    end else if (w_op[5:3] == OP_BR_BASE[5:3]) begin
      o_ctrl.pcctl   = w_op[2:0];
    end else if (w_op == OP_HALT) begin
      o_ctrl.is_halt = 1'b1;
    end else begin
      o_ctrl.legal   = 1'b0;
    end
  end

endmodule : j17_decoder
`default_nettype wire

// File: rtl/j17_control_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | j17_control_unit
// | Fetch/decode/sequence FSM driving the J17 DATAPATH control bus and PC advance.
// | Rev 1.0
// +-----------------------------------------------------------------------------
module j17_control_unit
  import j17_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [31:0]       PC,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [4:0]        alucode,
  output logic [4:0]        op1,
  output logic [19:0]       op2,
  output logic              imControl,
  output logic              regenable,
  output logic [1:0]        ramenable,
  output logic [2:0]        pcControl,
  output logic [1:0]        writecode,
  output logic              pc_en,
  output logic              halted,
  output logic              illegal,
  output logic              fetch_err
);

  localparam logic [7:0] C_TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t            r_state;
  logic [31:0]       r_instr;
  logic [7:0]        r_cnt;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_alucode;
  logic [4:0]        r_op1;
  logic [19:0]       r_op2;
  logic              r_imc;
  logic              r_regen;
  logic [1:0]        r_ramen;
  logic [2:0]        r_pcctl;
  logic [1:0]        r_wc;
  logic              r_pcen;
  logic              r_halted;
  logic              r_illegal;
  logic              r_ferr;

  ctrl_t             w_ctrl;
  logic              w_unused_pc;

  assign w_unused_pc = ^PC[31:ADDR_W];

  j17_decoder u_decoder (
    .i_instr (r_instr),
    .o_ctrl  (w_ctrl)
  );

  // All outputs are registered: each is loaded on the edge entering the state that shows it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_FETCH;
      r_instr   <= '0;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_alucode <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_imc     <= 1'b0;
      r_regen   <= 1'b0;
      r_ramen   <= RAMEN_IDLE;
      r_pcctl   <= '0;
      r_wc      <= WC_ALU;
      r_pcen    <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_regen   <= 1'b0;
      r_pcen    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          r_req   <= 1'b1;
          r_addr  <= PC[ADDR_W-1:0];
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // ack wins over an expiring counter in the same cycle
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_DECODE;
          end else if (r_cnt == C_TIMEOUT_M1) begin
            r_ferr   <= 1'b1;
            r_req    <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DECODE: begin
          r_alucode <= w_ctrl.alucode;
          r_op1     <= w_ctrl.op1;
          r_op2     <= w_ctrl.op2;
          r_imc     <= w_ctrl.imm;
          r_pcctl   <= w_ctrl.pcctl;
          r_wc      <= w_ctrl.wc;
          r_ramen   <= w_ctrl.ramen;
          if (w_ctrl.is_halt) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else if (w_ctrl.is_mem) begin
            r_state  <= ST_EXEC;
          end else begin
            r_regen   <= w_ctrl.regwr;
            r_pcen    <= 1'b1;
            r_illegal <= ~w_ctrl.legal;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= w_ctrl.is_mem ? ST_MEM : ST_FETCH;
        end
        ST_MEM: begin
          r_regen <= w_ctrl.regwr;
          r_pcen  <= 1'b1;
          r_state <= ST_WB;
        end
        ST_WB: begin
          r_ramen <= RAMEN_IDLE;
          r_state <= ST_FETCH;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign alucode   = r_alucode;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign imControl = r_imc;
  assign regenable = r_regen;
  assign ramenable = r_ramen;
  assign pcControl = r_pcctl;
  assign writecode = r_wc;
  assign pc_en     = r_pcen;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign fetch_err = r_ferr;

endmodule : j17_control_unit
`default_nettype wire

// File: tb/tb_j17_control_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_j17_control_unit
// | Directed table-driven bench for the J17 controller, plus reset/timeout/halt sequences.
// | Rev 1.0
// +-----------------------------------------------------------------------------
module tb_j17_control_unit;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] PC;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  alucode;
  logic [4:0]  op1;
  logic [19:0] op2;
  logic        imControl;
  logic        regenable;
  logic [1:0]  ramenable;
  logic [2:0]  pcControl;
  logic [1:0]  writecode;
  logic        pc_en;
  logic        halted;
  logic        illegal;
  logic        fetch_err;

  always #5 clock = ~clock;

  j17_control_unit #(.ADDR_W(10), .TIMEOUT(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .PC         (PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .alucode    (alucode),
    .op1        (op1),
    .op2        (op2),
    .imControl  (imControl),
    .regenable  (regenable),
    .ramenable  (ramenable),
    .pcControl  (pcControl),
    .writecode  (writecode),
    .pc_en      (pc_en),
    .halted     (halted),
    .illegal    (illegal),
    .fetch_err  (fetch_err)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          delay;
    logic [4:0]  alu;
    logic [4:0]  r1;
    logic [19:0] o2;
    logic        imc;
    logic [2:0]  pcc;
    logic [1:0]  wc;
    logic [1:0]  ram;
    int          regen;
    int          ill;
    int          cycles;
  } vec_t;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] r1,
                                     input logic b20, input logic [19:0] o2);
    return {op, r1, b20, o2};
  endfunction

  // Entry and exit: at a negedge while the controller sits in FETCH.
  task automatic run_vec(input vec_t v);
    int   wcnt = 0, pcen_n = 0, regen_n = 0, ill_n = 0, ram_n = 0, ram_bad = 0;
    int   pcen_cyc = -1, regen_cyc = -1;
    bit   acked = 1'b0, done = 1'b0, last;
    logic [4:0]  s_alu = '0, s_op1 = '0;
    logic [19:0] s_op2 = '0;
    logic [5:0]  s_ctl = '0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clock);
      imem_ack = 1'b0;
      last = (pcen_cyc >= 0) && (cyc == pcen_cyc + 1);
      if (regenable) begin regen_n++; regen_cyc = cyc; end
      if (illegal) ill_n++;
      if (ramenable != 2'b00) begin
        ram_n++;
        if (ramenable !== v.ram) ram_bad++;
      end
      if (pc_en) begin
        pcen_n++; pcen_cyc = cyc;
        s_alu = alucode; s_op1 = op1; s_op2 = op2;
        s_ctl = {imControl, pcControl, writecode};
        PC = PC + 32'd4;
      end
      if (last) begin
        chk({v.name, "_hold"}, {imControl, pcControl, writecode, alucode, op1},
            {v.imc, v.pcc, v.wc, v.alu, v.r1});
        chk({v.name, "_hold_op2"}, op2, v.o2);
        chk({v.name, "_ram_idle"}, ramenable, 2'b00);
        done = 1'b1;
      end
      if (imem_req && !acked) begin
        if (wcnt == 0) chk({v.name, "_addr"}, imem_addr, PC[9:0]);
        if (wcnt == v.delay) begin
          imem_ack = 1'b1; imem_rdata = v.instr; acked = 1'b1;
        end else begin
          wcnt++;
        end
      end
    end
    chk({v.name, "_done"}, done, 1'b1);
    chk({v.name, "_alucode"}, s_alu, v.alu);
    chk({v.name, "_op1"}, s_op1, v.r1);
    chk({v.name, "_op2"}, s_op2, v.o2);
    chk({v.name, "_imc_pcc_wc"}, s_ctl, {v.imc, v.pcc, v.wc});
    chk({v.name, "_regen_n"}, regen_n, v.regen);
    chk({v.name, "_pcen_n"}, pcen_n, 1);
    chk({v.name, "_illegal_n"}, ill_n, v.ill);
    chk({v.name, "_cycles"}, pcen_cyc + 1, v.cycles);
    chk({v.name, "_ram_n"}, ram_n, (v.ram != 2'b00) ? 3 : 0);
    chk({v.name, "_ram_bad"}, ram_bad, 0);
    chk({v.name, "_ferr"}, fetch_err, 1'b0);
    if (v.regen != 0) chk({v.name, "_regen_with_pcen"}, regen_cyc, pcen_cyc);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    imem_ack = 1'b0;
    @(negedge clock);
    resetn   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pe, rg, rq;
    //                name       instr                                   dly alu    r1     o2        imc   pcc   wc    ram    rg il cyc
    vecs[0]  = '{"add",    mk(6'h01, 5'd10, 1'b0, 20'h80000),  2, 5'd1,  5'd10, 20'h80000, 1'b0, 3'd0, 2'd0, 2'b00, 1, 0, 6};
    vecs[1]  = '{"addi",   mk(6'h15, 5'd7,  1'b1, 20'h12345),  0, 5'd5,  5'd7,  20'h12345, 1'b1, 3'd0, 2'd0, 2'b00, 1, 0, 4};
    vecs[2]  = '{"imm_hi", mk(6'h1B, 5'd31, 1'b0, 20'hFFFFF),  1, 5'd11, 5'd31, 20'hFFFFF, 1'b1, 3'd0, 2'd0, 2'b00, 1, 0, 5};
    vecs[3]  = '{"alu_hi", mk(6'h0B, 5'd0,  1'b0, 20'h00001),  0, 5'd11, 5'd0,  20'h00001, 1'b0, 3'd0, 2'd0, 2'b00, 1, 0, 4};
    vecs[4]  = '{"load",   mk(6'h20, 5'd3,  1'b0, 20'h00040),  0, 5'd0,  5'd3,  20'h00040, 1'b1, 3'd0, 2'd1, 2'b01, 1, 0, 6};
    vecs[5]  = '{"store",  mk(6'h21, 5'd9,  1'b0, 20'h0A5A5),  1, 5'd0,  5'd9,  20'h0A5A5, 1'b1, 3'd0, 2'd0, 2'b10, 0, 0, 7};
    vecs[6]  = '{"beq",    mk(6'h29, 5'd2,  1'b0, 20'h21400),  0, 5'd0,  5'd2,  20'h21400, 1'b0, 3'd1, 2'd0, 2'b00, 0, 0, 4};
    vecs[7]  = '{"br7_lateack", mk(6'h2F, 5'd1, 1'b1, 20'h00C00), 3, 5'd0, 5'd1, 20'h00C00, 1'b0, 3'd7, 2'd0, 2'b00, 0, 0, 7};
    vecs[8]  = '{"nop",    mk(6'h00, 5'd5,  1'b0, 20'h00003),  0, 5'd0,  5'd5,  20'h00003, 1'b0, 3'd0, 2'd0, 2'b00, 0, 0, 4};
    vecs[9]  = '{"ill_30", mk(6'h30, 5'd4,  1'b0, 20'h00010),  0, 5'd0,  5'd4,  20'h00010, 1'b0, 3'd0, 2'd0, 2'b00, 0, 1, 4};
    vecs[10] = '{"ill_0c", mk(6'h0C, 5'd6,  1'b0, 20'h00020),  1, 5'd0,  5'd6,  20'h00020, 1'b0, 3'd0, 2'd0, 2'b00, 0, 1, 5};
    vecs[11] = '{"ill_10", mk(6'h10, 5'd8,  1'b0, 20'h00030),  0, 5'd0,  5'd8,  20'h00030, 1'b0, 3'd0, 2'd0, 2'b00, 0, 1, 4};

    resetn     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    PC         = 32'hABCD_07F8;
    @(negedge clock);
    @(negedge clock);
    chk("rst_req_addr", {imem_req, imem_addr}, 11'd0);
    chk("rst_fields", {alucode, op1, imControl, pcControl, writecode, ramenable}, 20'd0);
    chk("rst_op2", op2, 20'd0);
    chk("rst_strobes", {regenable, pc_en, illegal, halted, fetch_err}, 5'd0);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset during MEM of a LOAD; also an ack during DECODE must be ignored.
    @(negedge clock);
    chk("mr_req", imem_req, 1'b1);
    imem_ack = 1'b1; imem_rdata = mk(6'h20, 5'd3, 1'b0, 20'h00040);
    @(negedge clock);
    imem_ack = 1'b1; imem_rdata = mk(6'h01, 5'd12, 1'b0, 20'h00000);
    @(negedge clock);
    imem_ack = 1'b0;
    chk("mr_exec_ram", ramenable, 2'b01);
    chk("mr_exec_op1", op1, 5'd3);
    @(negedge clock);
    chk("mr_mem_ram", ramenable, 2'b01);
    chk("mr_mem_noack_overwrite", op1, 5'd3);
    chk("mr_mem_strobes", {regenable, pc_en}, 2'b00);
    #1 resetn = 1'b0;
    #1;
    chk("mr_async_clear", {ramenable, op1, writecode, imControl, regenable, pc_en, imem_req}, 12'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("mr_refetch_req", imem_req, 1'b1);
    chk("mr_refetch_addr", imem_addr, PC[9:0]);
    chk("mr_refetch_strobes", {regenable, pc_en}, 2'b00);
    do_reset();

    // Fetch timeout with TIMEOUT=4, then a stray ack in HALT.
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clock);
      imem_ack = 1'b0;
      if (cyc == 4) chk("to_wait4", {imem_req, fetch_err}, 2'b10);
      if (cyc == 5) begin
        chk("to_ferr", fetch_err, 1'b1);
        chk("to_req_drop", imem_req, 1'b0);
        chk("to_halted", halted, 1'b1);
        imem_ack = 1'b1; imem_rdata = mk(6'h01, 5'd1, 1'b0, 20'h0);
      end
      if (cyc == 7) chk("to_sticky_nostrobe", {fetch_err, regenable, pc_en, imem_req}, 4'b1000);
    end
    do_reset();
    chk("to_reset_clears", {fetch_err, halted}, 2'b00);

    // HALT opcode: halted asserts after DECODE and stays; nothing else fires.
    pe = 0; rg = 0; rq = 0;
    @(negedge clock);
    imem_ack = 1'b1; imem_rdata = mk(6'h3F, 5'd0, 1'b0, 20'h0);
    @(negedge clock);
    imem_ack = 1'b0;
    chk("halt_decode", halted, 1'b0);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clock);
      if (pc_en) pe++;
      if (regenable) rg++;
      if (imem_req) rq++;
      if (cyc == 0) chk("halt_set", halted, 1'b1);
    end
    chk("halt_sticky", halted, 1'b1);
    chk("halt_quiet", {pe[7:0], rg[7:0], rq[7:0]}, 24'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_j17_control_unit
`default_nettype wire
